param_seq_detector: RTL and testbench
=====================================

# param_seq_detector

Parametrised serial sequence detector: the next generation of the fixed 4-state "1011" Mealy detector. A runtime-loaded pattern of 1..PAT_W bits is compared against a serial bit stream qualified by `in_valid`. Overlapping or non-overlapping match mode is selectable, and matches are counted. It sits on the same single-bit serial paths as the fixed detector and drives the same same-cycle Mealy flag `z`.

## Interface
- `PAT_W`, 8: maximum pattern length in bits (≥2).
- `LEN_W`, `$clog2(PAT_W+1)`: width of `pat_len`.
- `CNT_W`, 8: width of the match counter.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `x` in 1: serial data bit.
- `in_valid` in 1: `x` is consumed on this edge only when high.
- `cfg_load` in 1: one-cycle strobe that latches `pattern`, `pat_len`, `overlap`.
- `pattern` in PAT_W: target bits; `pattern[pat_len-1]` is the first bit received, `pattern[0]` the last.
- `pat_len` in LEN_W: active pattern length; legal range 1..PAT_W.
- `overlap` in 1: 1 = overlapping matches allowed; 0 = history restarts after each match.
- `clr_cnt` in 1: synchronous clear of `match_cnt`.
- `z` out 1: Mealy match flag, combinational from state and current `x`/`in_valid`.
- `match_cnt` out CNT_W: number of matches, saturating.
- `cnt_sat` out 1: high while `match_cnt` is all-ones.
- `cfg_err` out 1: sticky flag; the last `cfg_load` was rejected.
- `armed` out 1: high when a valid configuration is loaded (state ≠ UNCFG).

## Operation
- Registers:
  - history shift register `hist[PAT_W-1:0]` (newest bit in LSB);
  - fill counter `fill` (0..PAT_W, saturating);
  - latched `cfg_pat`, `cfg_len`, `cfg_ovl`.
- FSM states: UNCFG, FILL, SEARCH.
  - UNCFG: input bits are ignored and `z`=0. A legal `cfg_load` moves to FILL.
  - FILL: `fill < cfg_len-1`. Each valid bit shifts into `hist` and increments `fill`. When `fill` reaches `cfg_len-1`, move to SEARCH.
  - SEARCH: `z` = `in_valid` AND ({hist, x} low `cfg_len` bits == `cfg_pat` low `cfg_len` bits).
    - On a valid bit with no match: shift and stay in SEARCH.
    - On a match with `cfg_ovl`=1: shift and stay in SEARCH.
    - On a match with `cfg_ovl`=0: clear `hist` and `fill`, go to FILL. If `cfg_len`=1, stay in SEARCH.
- `cfg_len`=1 enters SEARCH directly from a legal load.
- Legal `cfg_load` (1 ≤ `pat_len` ≤ PAT_W):
  - latches the configuration and clears `hist`, `fill` and `cfg_err`;
  - goes to FILL, or to SEARCH when `pat_len`=1;
  - does not clear `match_cnt`.
- Illegal `cfg_load` (`pat_len`=0 or > PAT_W): sets `cfg_err`. The configuration, state and history are unchanged.
- `cfg_load` with `in_valid` in the same cycle: the configuration is applied, the `x` bit is discarded, and `z`=0 that cycle.
- Match counter:
  - increments on each edge where `z`=1;
  - saturates at 2^CNT_W−1;
  - `clr_cnt` has priority over a simultaneous increment, so the result is 0.
- `in_valid`=0: no state change; `z`=0.

## Timing
- `z` is valid in the same cycle as the completing bit (zero latency, Mealy), and is qualified by `in_valid`.
- `match_cnt` and `cnt_sat` update at the rising edge where `z`=1, i.e. one cycle after `z` is observed.
- A configuration loaded at edge N takes effect for the bit presented at edge N+1.
- `reset` low at an edge forces the following, regardless of other inputs including `cfg_load`:
  - state UNCFG, `hist`=0, `fill`=0;
  - `cfg_pat`=0, `cfg_len`=0, `cfg_ovl`=0;
  - `match_cnt`=0, `cnt_sat`=0, `cfg_err`=0, `armed`=0, `z`=0.
- Reset mid-pattern discards the partial history. Reconfiguration is required after reset.

## Configuration
- `SEQDET_MATCH_CNT_EN`:
  - Defined: the `match_cnt`/`cnt_sat` counter logic and `clr_cnt` handling are built as specified.
  - Undefined: `match_cnt` is tied to 0, `cnt_sat` is tied to 0, `clr_cnt` is ignored, and no counter flops are inferred. Detection and `z` are unaffected.

## Test plan
- Reset, then load `pattern`=4'b1011, `pat_len`=4, `overlap`=1. Feed 1,0,1,1,0,1,1 → `z`=1 on bit 4 and bit 7; `match_cnt`=2.
- Same pattern with `overlap`=0 and stream 1,0,1,1,0,1,1 → `z`=1 on bit 4 only; `match_cnt`=1.
- `pat_len`=1, `pattern`=1, stream 1,1,0,1 → `z`=1,1,0,1; `match_cnt`=3. Then load `pat_len`=0 → `cfg_err`=1, and detection continues unchanged.
- CNT_W=2, `pattern`=2'b11, `pat_len`=2, overlap, six 1s → `match_cnt` saturates at 3 with `cnt_sat`=1. Then `clr_cnt` together with a matching bit → `match_cnt`=0.
- Load 1011, feed 1,0,1, then drive `reset` low for one edge, then feed 1 → `z`=0 and `armed`=0. Reload and feed 1,0,1,1 → `z`=1 on bit 4.
- Load 1011 and feed 1,0,1. Assert `cfg_load` (`pattern`=3'b110, `pat_len`=3) with `in_valid`=1 and `x`=1 → `z`=0 and the bit is dropped. Then feed 1,1,0 → `z`=1 on the third bit.

Source files
------------

// File: rtl/param_seq_detector.sv
// param_seq_detector: runtime-configurable serial sequence detector with a
// Mealy match flag, overlap/non-overlap modes and an optional match counter.
// Optional feature macro: SEQDET_MATCH_CNT_EN (builds match_cnt/cnt_sat/clr_cnt).
module param_seq_detector #(
    parameter int PAT_W = 8,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             in_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat,
    output logic             cfg_err,
    output logic             armed
);

    typedef enum logic [1:0] {
        UNCFG,
        FILL,
        SEARCH
    } state_t;

    state_t           state, state_nxt;
    logic [PAT_W-1:0] hist, hist_nxt;
    logic [LEN_W-1:0] fill, fill_nxt;
    logic [PAT_W-1:0] cfg_pat, cfg_pat_nxt;
    logic [LEN_W-1:0] cfg_len, cfg_len_nxt;
    logic             cfg_ovl, cfg_ovl_nxt;
    logic             cfg_err_nxt;
    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] window;
    logic             hit;
    logic             load_ok;

    // Candidate window: stored history with the current bit appended as newest.
    assign window  = {hist[PAT_W-2:0], x};
    assign hit     = ((window ^ cfg_pat) & mask) == '0;
    assign load_ok = (pat_len != '0) && (pat_len <= LEN_W'(PAT_W));
    assign armed   = (state != UNCFG);

    // Mask selecting the low cfg_len bits of the window for comparison.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < 32'(cfg_len));
        end
    end

    // Next-state, datapath and Mealy output; a load takes precedence over data.
    always_comb begin
        state_nxt   = state;
        hist_nxt    = hist;
        fill_nxt    = fill;
        cfg_pat_nxt = cfg_pat;
        cfg_len_nxt = cfg_len;
        cfg_ovl_nxt = cfg_ovl;
        cfg_err_nxt = cfg_err;
        z           = 1'b0;
        if (cfg_load) begin
            if (load_ok) begin
                cfg_pat_nxt = pattern;
                cfg_len_nxt = pat_len;
                cfg_ovl_nxt = overlap;
                hist_nxt    = '0;
                fill_nxt    = '0;
                cfg_err_nxt = 1'b0;
                state_nxt   = (pat_len == LEN_W'(1)) ? SEARCH : FILL;
            end else begin
                cfg_err_nxt = 1'b1;
            end
        end else if (in_valid) begin
            case (state)
                FILL: begin
                    hist_nxt = window;
                    fill_nxt = fill + LEN_W'(1);
                    if (fill + LEN_W'(1) == cfg_len - LEN_W'(1)) begin
                        state_nxt = SEARCH;
                    end
                end
                SEARCH: begin
                    z = reset & hit;
                    if (hit && !cfg_ovl) begin
                        hist_nxt  = '0;
                        fill_nxt  = '0;
                        state_nxt = (cfg_len == LEN_W'(1)) ? SEARCH : FILL;
                    end else begin
                        hist_nxt = window;
                        if (fill != LEN_W'(PAT_W)) begin
                            fill_nxt = fill + LEN_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State, history and configuration registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= UNCFG;
            hist    <= '0;
            fill    <= '0;
            cfg_pat <= '0;
            cfg_len <= '0;
            cfg_ovl <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            hist    <= hist_nxt;
            fill    <= fill_nxt;
            cfg_pat <= cfg_pat_nxt;
            cfg_len <= cfg_len_nxt;
            cfg_ovl <= cfg_ovl_nxt;
            cfg_err <= cfg_err_nxt;
        end
    end

`ifdef SEQDET_MATCH_CNT_EN
    assign cnt_sat = &match_cnt;

    // Saturating match counter; clear wins over a simultaneous match.
    always_ff @(posedge clk) begin
        if (!reset) begin
            match_cnt <= '0;
        end else if (clr_cnt) begin
            match_cnt <= '0;
        end else if (z && !cnt_sat) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign match_cnt      = '0;
    assign cnt_sat        = 1'b0;
`endif

endmodule

// File: tb/tb_param_seq_detector.sv
// Self-checking bench for param_seq_detector: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_param_seq_detector;

`ifdef SEQDET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       x;
    logic       in_valid;
    logic       cfg_load;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic       overlap;
    logic       clr_cnt;
    logic       z;
    logic [7:0] match_cnt;
    logic       cnt_sat;
    logic       cfg_err;
    logic       armed;

    param_seq_detector #(
        .PAT_W(8),
        .LEN_W(4),
        .CNT_W(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .in_valid (in_valid),
        .cfg_load (cfg_load),
        .pattern  (pattern),
        .pat_len  (pat_len),
        .overlap  (overlap),
        .clr_cnt  (clr_cnt),
        .z        (z),
        .match_cnt(match_cnt),
        .cnt_sat  (cnt_sat),
        .cfg_err  (cfg_err),
        .armed    (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int step     = 0;
    logic [31:0] zlog;

    // Reference model: bits received since the last (re)start, newest at back.
    bit         m_armed;
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         m_q[$];
    int         m_cnt;
    bit         m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
        end
    endtask

    // True when the last m_len received bits (ending with bx) spell the pattern.
    function automatic bit model_hit(input logic bx);
        bit b;
        if (m_len < 1 || m_q.size() < m_len - 1) return 1'b0;
        for (int i = 0; i < m_len; i++) begin
            b = (i == 0) ? bx : m_q[m_q.size() - i];
            if (b != m_pat[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic cycle(input logic vx, input logic vv, input logic ld,
                         input logic [7:0] pat, input logic [3:0] len,
                         input logic ovl, input logic clr, input logic rst);
        logic z_exp;
        @(negedge clk);
        x        = vx;
        in_valid = vv;
        cfg_load = ld;
        pattern  = pat;
        pat_len  = len;
        overlap  = ovl;
        clr_cnt  = clr;
        reset    = rst;
        step++;
        #1;
        z_exp = rst && m_armed && vv && !ld && model_hit(vx);
        chk("z", z, z_exp);
        zlog = {zlog[30:0], z};
        @(posedge clk);
        if (!rst) begin
            m_armed = 0; m_pat = '0; m_len = 0; m_ovl = 0;
            m_q.delete(); m_cnt = 0; m_err = 0;
        end else begin
            if (clr) m_cnt = 0;
            else if (z_exp && m_cnt < 255) m_cnt++;
            if (ld) begin
                if (len >= 1 && len <= 8) begin
                    m_armed = 1; m_pat = pat; m_len = int'(len); m_ovl = ovl;
                    m_q.delete(); m_err = 0;
                end else begin
                    m_err = 1;
                end
            end else if (m_armed && vv) begin
                if (z_exp && !m_ovl) m_q.delete();
                else begin
                    m_q.push_back(vx);
                    if (m_q.size() > 8) void'(m_q.pop_front());
                end
            end
        end
        #1;
        chk("match_cnt", match_cnt, CNT_EN ? m_cnt : 0);
        chk("cnt_sat", cnt_sat, CNT_EN && m_cnt == 255);
        chk("cfg_err", cfg_err, m_err);
        chk("armed", armed, m_armed);
    endtask

    task automatic feed(input logic b);
        cycle(b, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        cycle(1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0, 1'b1);
    endtask

    task automatic clear_cnt();
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        x = 0; in_valid = 0; cfg_load = 0; pattern = '0; pat_len = '0;
        overlap = 0; clr_cnt = 0; reset = 0; zlog = '0;
        m_armed = 0; m_pat = '0; m_len = 0; m_ovl = 0; m_cnt = 0; m_err = 0;

        // Reset state
        cycle(1'b1, 1'b1, 1'b1, 8'h0b, 4'd4, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_armed", armed, 1'b0);
        chk("rst_cnt", match_cnt, 32'd0);

        // Overlapping 1011
        load(8'h0b, 4'd4, 1'b1);
        zlog = '0;
        feed(1); feed(0); feed(1); feed(1); feed(0); feed(1); feed(1);
        chk("ovl_zseq", zlog[6:0], 7'b0001001);
        chk("ovl_cnt", match_cnt, CNT_EN ? 32'd2 : 32'd0);

        // Non-overlapping 1011
        clear_cnt();
        load(8'h0b, 4'd4, 1'b0);
        zlog = '0;
        feed(1); feed(0); feed(1); feed(1); feed(0); feed(1); feed(1);
        chk("novl_zseq", zlog[6:0], 7'b0001000);
        chk("novl_cnt", match_cnt, CNT_EN ? 32'd1 : 32'd0);

        // Single-bit pattern, then an illegal load
        clear_cnt();
        load(8'h01, 4'd1, 1'b0);
        zlog = '0;
        feed(1); feed(1); feed(0); feed(1);
        chk("len1_zseq", zlog[3:0], 4'b1101);
        chk("len1_cnt", match_cnt, CNT_EN ? 32'd3 : 32'd0);
        load(8'h00, 4'd0, 1'b1);
        chk("bad_err", cfg_err, 1'b1);
        load(8'h00, 4'd9, 1'b1);
        chk("bad9_err", cfg_err, 1'b1);
        zlog = '0;
        feed(1); feed(0);
        chk("bad_keep", zlog[1:0], 2'b10);

        // Counter saturation and clear-with-match
        clear_cnt();
        load(8'h03, 4'd2, 1'b1);
        for (int i = 0; i < 260; i++) feed(1);
        chk("sat_cnt", match_cnt, CNT_EN ? 32'd255 : 32'd0);
        chk("sat_flag", cnt_sat, CNT_EN);
        cycle(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("clr_win_z", zlog[0], 1'b1);
        chk("clr_win_cnt", match_cnt, 32'd0);

        // Reset mid-pattern
        load(8'h0b, 4'd4, 1'b1);
        feed(1); feed(0); feed(1);
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        feed(1);
        chk("midrst_z", zlog[0], 1'b0);
        chk("midrst_armed", armed, 1'b0);
        load(8'h0b, 4'd4, 1'b1);
        zlog = '0;
        feed(1); feed(0); feed(1); feed(1);
        chk("reload_zseq", zlog[3:0], 4'b0001);

        // Load together with a valid bit
        load(8'h0b, 4'd4, 1'b1);
        feed(1); feed(0); feed(1);
        cycle(1'b1, 1'b1, 1'b1, 8'h06, 4'd3, 1'b1, 1'b0, 1'b1);
        chk("ldv_z", zlog[0], 1'b0);
        zlog = '0;
        feed(1); feed(1); feed(0);
        chk("ldv_zseq", zlog[2:0], 3'b001);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic       r_ld;
            logic [3:0] r_len;
            r_ld  = ($urandom_range(0, 29) == 0);
            r_len = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(1, 4));
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), r_ld,
                  8'($urandom), r_len, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 199) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
